// File: rtl/nn_axi_lite_slave.sv
// AXI4-Lite register slave exposing four 32-bit slots to the NN core.
// Optional macro NN_AXI_DECERR_EN: slots 4-15 return DECERR instead of aliasing slots 0-3.
module nn_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [127:0]                  REG_OUT,
    output logic [3:0]                    REG_WR_PULSE
);

    localparam int unsigned DW     = 32;
    localparam int unsigned NSLOT  = 4;
    localparam int unsigned REGW   = DW * NSLOT;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  DECERR = 2'b11;

    logic [REGW-1:0] regs_q, regs_d;
    logic            aw_held_q, aw_held_d;
    logic [1:0]      aw_slot_q, aw_slot_d;
    logic            aw_bad_q, aw_bad_d;
    logic            w_held_q, w_held_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [3:0]      pulse_q, pulse_d;

    logic aw_hs_c, w_hs_c, ar_hs_c, aw_bad_c, ar_bad_c, commit_c;
    logic unused_c;

    assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // Unmapped-slot decode for the incoming addresses
    always_comb begin
`ifdef NN_AXI_DECERR_EN
        aw_bad_c = (S_AXI_AWADDR[5:4] != 2'b00);
        ar_bad_c = (S_AXI_ARADDR[5:4] != 2'b00);
`else
        aw_bad_c = 1'b0;
        ar_bad_c = 1'b0;
`endif
    end

    always_comb begin
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        aw_slot_d = aw_slot_q;
        aw_bad_d  = aw_bad_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        pulse_d   = 4'b0000;

        aw_hs_c = S_AXI_AWVALID && awready_q;
        w_hs_c  = S_AXI_WVALID && wready_q;
        ar_hs_c = S_AXI_ARVALID && arready_q;

        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (aw_hs_c) begin
            aw_held_d = 1'b1;
            aw_slot_d = S_AXI_AWADDR[3:2];
            aw_bad_d  = aw_bad_c;
        end
        if (w_hs_c) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end

        // Address and data both available (held or arriving now): commit
        commit_c = aw_held_d && w_held_d;
        if (commit_c) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_bad_d ? DECERR : OKAY;
            if (!aw_bad_d) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_d[b]) begin
                        regs_d[{aw_slot_d, 5'd0} + 7'(8 * b) +: 8] = wdata_d[8*b +: 8];
                    end
                end
                pulse_d[aw_slot_d] = 1'b1;
            end
        end

        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        // Read samples regs_q, so a same-edge write is not yet visible
        if (ar_hs_c) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_bad_c ? DECERR : OKAY;
            rdata_d  = ar_bad_c ? '0 : regs_q[{S_AXI_ARADDR[3:2], 5'd0} +: DW];
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
        arready_d = !rvalid_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q    <= '0;
            aw_held_q <= 1'b0;
            aw_slot_q <= 2'b00;
            aw_bad_q  <= 1'b0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            pulse_q   <= 4'b0000;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            aw_slot_q <= aw_slot_d;
            aw_bad_q  <= aw_bad_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign REG_OUT       = regs_q;
    assign REG_WR_PULSE  = pulse_q;

endmodule

// File: tb/tb_nn_axi_lite_slave.sv
// Directed self-checking bench for nn_axi_lite_slave (default build or NN_AXI_DECERR_EN).
module tb_nn_axi_lite_slave;

    logic         clk = 1'b0;
    logic         areset;
    logic [5:0]   awaddr, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nn_axi_lite_slave dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .REG_OUT       (reg_out),
        .REG_WR_PULSE  (wr_pulse)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write with AW and W presented together; returns response and BVALID latency
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        int  n;
        logic aw_go, w_go;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge clk);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            n++;
        end
        check_eq("wr_handshake_done", {awvalid, wvalid}, 2'b00);
        lat = 0;
        while (!bvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("wr_bvalid_seen", bvalid, 1'b1);
        resp = bresp;
    endtask

    // Read; checks RVALID exactly one cycle after the AR handshake
    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_arready", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("rd_rvalid_1cyc", rvalid, 1'b1);
        d = rdata;
        resp = rresp;
    endtask

    logic [31:0] rd;
    logic [1:0]  rsp;
    int          lat;
    logic        seen;

    initial begin
        areset = 1'b1;
        awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 0; rready = 0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_handshake", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check_eq("rst_resp_rdata", {bresp, rresp, rdata, wr_pulse}, 40'h0);
        check_eq("rst_regout", reg_out, 128'h0);
        areset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready_rise", {awready, wready, arready}, 3'b111);

        // Same-cycle AW/W, then read back
        axi_write(6'h00, 32'h0101FFFF, 4'hF, rsp, lat);
        check_eq("w0_bresp", rsp, 2'b00);
        check_eq("w0_latency", lat, 0);
        axi_read(6'h00, rd, rsp);
        check_eq("r0_data", rd, 32'h0101FFFF);
        check_eq("r0_resp", rsp, 2'b00);

        // AW three cycles ahead of W
        @(negedge clk);
        awaddr = 6'h04; awvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("aw_only_no_bvalid", {bvalid, awready}, 2'b00);
            if (i < 2) @(negedge clk);
        end
        wdata = 32'hABCD0001; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check_eq("late_w_bvalid", bvalid, 1'b1);
        check_eq("pulse_slot1", wr_pulse, 4'b0010);
        @(negedge clk);
        check_eq("pulse_one_cycle", wr_pulse, 4'b0000);
        axi_read(6'h04, rd, rsp);
        check_eq("r1_data", rd, 32'hABCD0001);

        // Byte strobes: 0101 updates bytes 0 and 2, 0110 updates bytes 1 and 2
        axi_write(6'h08, 32'hDEAD0011, 4'hF, rsp, lat);
        axi_write(6'h08, 32'hFFFFFFFF, 4'b0101, rsp, lat);
        axi_read(6'h08, rd, rsp);
        check_eq("strb_0101", rd, 32'hDEFF00FF);
        axi_write(6'h08, 32'hDEAD0011, 4'hF, rsp, lat);
        axi_write(6'h08, 32'hFFFFFFFF, 4'b0110, rsp, lat);
        axi_read(6'h08, rd, rsp);
        check_eq("strb_0110", rd, 32'hDEFFFF11);
        axi_write(6'h08, 32'h00000000, 4'b0000, rsp, lat);
        check_eq("strb_0000_bresp", rsp, 2'b00);
        axi_read(6'h08, rd, rsp);
        check_eq("strb_0000_data", rd, 32'hDEFFFF11);

        // Read and write to slot 0 on the same edge: read sees the old value
        @(negedge clk);
        awaddr = 6'h00; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h00; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("same_edge_valids", {bvalid, rvalid}, 2'b11);
        check_eq("same_edge_rdata", rdata, 32'h0101FFFF);
        axi_read(6'h00, rd, rsp);
        check_eq("same_edge_after", rd, 32'h11111111);

        // Write-response backpressure
        @(negedge clk);
        bready = 1'b0;
        awaddr = 6'h0C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_b_hold", {bvalid, awready, wready}, 3'b100);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check_eq("bp_b_release", {bvalid, awready, wready}, 3'b011);

        // Read-data backpressure
        araddr = 6'h0C; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_r_hold", {rvalid, arready, rdata}, {2'b10, 32'h12345678});
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        check_eq("bp_r_release", {rvalid, arready}, 2'b01);

        check_eq("regout_all", reg_out, {32'h12345678, 32'hDEFFFF11, 32'hABCD0001, 32'h11111111});

        // Upper slot 5 (0x14)
        axi_write(6'h14, 32'hBEEF0011, 4'hF, rsp, lat);
`ifdef NN_AXI_DECERR_EN
        check_eq("hi_bresp", rsp, 2'b11);
        axi_read(6'h04, rd, rsp);
        check_eq("hi_slot1", rd, 32'hABCD0001);
        axi_read(6'h14, rd, rsp);
        check_eq("hi_read", {rsp, rd}, {2'b11, 32'h0});
`else
        check_eq("hi_bresp", rsp, 2'b00);
        axi_read(6'h04, rd, rsp);
        check_eq("hi_slot1", rd, 32'hBEEF0011);
        axi_read(6'h14, rd, rsp);
        check_eq("hi_read", {rsp, rd}, {2'b00, 32'hBEEF0011});
`endif

        // Reset between AW and W: the held address must be discarded
        @(negedge clk);
        awaddr = 6'h08; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; areset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_outputs", {awready, wready, arready, bvalid, rvalid, wr_pulse}, 9'b0);
        check_eq("mid_rst_regout", reg_out, 128'h0);
        areset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready_rise", {awready, wready, arready}, 3'b111);
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bvalid) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("mid_rst_no_bvalid", seen, 1'b0);
        check_eq("mid_rst_regs_zero", reg_out, 128'h0);
        for (int s = 0; s < 4; s++) begin
            axi_read(6'(4 * s), rd, rsp);
            check_eq("mid_rst_read", rd, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
